// File: rtl/reg_file_rd2w1_pkg.sv
// Shared CPU datapath constants: default register-file geometry and the
// architectural register indices.
package reg_file_rd2w1_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  localparam int REG_ZERO = 0;

  // ABI-reserved registers.
  localparam int REG_SP = 6;
  localparam int REG_RA = 7;

  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_rd2w1_word.sv
// One general-purpose register: a DATA_W-bit word with load enable and an
// asynchronous active-low clear.
import reg_file_rd2w1_pkg::*;

module reg_word #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_rd2w1.sv
// Two-read / one-write register file with hardwired R0 and a write-through
// bypass so write-back data is visible on the read ports in its own cycle.
import reg_file_rd2w1_pkg::*;

module reg_file_rd2w1 #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              wr_ack
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:1] load_vec;
  logic wr_accept;

  assign wr_accept = we && (waddr != ZERO_IDX);

  // R0 has no storage; it reads as a constant zero.
  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
    assign load_vec[i] = we && (waddr == ADDR_W'(i));

    reg_word #(
      .DATA_W (DATA_W)
    ) u_word (
      .clk  (clk),
      .rst  (rst),
      .load (load_vec[i]),
      .d    (wdata),
      .q    (regs[i])
    );
  end

  // Reset forces zero on every address, overriding both storage and bypass.
  always_comb begin
    rdata_a = '0;
    if (rst && (raddr_a != ZERO_IDX)) begin
      if (we && (waddr == raddr_a)) begin
        rdata_a = wdata;
      end else begin
        rdata_a = regs[raddr_a];
      end
    end
  end

  always_comb begin
    rdata_b = '0;
    if (rst && (raddr_b != ZERO_IDX)) begin
      if (we && (waddr == raddr_b)) begin
        rdata_b = wdata;
      end else begin
        rdata_b = regs[raddr_b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_accept;
    end
  end

endmodule

// File: tb/tb_reg_file_rd2w1.sv
// Self-checking bench for reg_file_rd2w1: directed scenarios plus randomized
// traffic compared against an array model of the register file.
module tb_reg_file_rd2w1;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        wr_ack;

  logic [15:0] model [8];
  logic        ack_exp;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  reg_file_rd2w1 dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .wr_ack  (wr_ack)
  );

  function automatic logic [15:0] exp_read(input logic [2:0] a);
    if (!rst) return 16'h0;
    if (a == 3'd0) return 16'h0;
    if (we && (waddr == a)) return wdata;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
  endtask

  // Advance one rising edge, apply the write rule to the model, return #1 later.
  task automatic tick();
    @(posedge clk);
    ack_exp = rst && we && (waddr != 3'd0);
    if (ack_exp) model[waddr] = wdata;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
    raddr_a = 3'd3; raddr_b = 3'd0;
    clear_model();
    tick();
    tick();
    n_checks++;
    if (rdata_a !== 16'h0) $display("FAIL reset_rdata_a: got %h want 0000", rdata_a);
    else n_pass++;
    n_checks++;
    if (wr_ack !== 1'b0) $display("FAIL reset_wr_ack: got %b want 0", wr_ack);
    else n_pass++;
    we = 1'b0;
    #2 rst = 1'b1;
    for (int i = 1; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(i);
      #1;
      n_checks++;
      if (rdata_a !== 16'h0 || rdata_b !== 16'h0)
        $display("FAIL reset_release_R%0d: got a=%h b=%h want 0000", i, rdata_a, rdata_b);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    we = 1'b1; waddr = 3'd5; wdata = 16'h1234;
    tick();
    n_checks++;
    if (wr_ack !== 1'b1) $display("FAIL basic_ack1: got %b want 1", wr_ack);
    else n_pass++;
    waddr = 3'd2; wdata = 16'hA5A5;
    tick();
    n_checks++;
    if (wr_ack !== 1'b1) $display("FAIL basic_ack2: got %b want 1", wr_ack);
    else n_pass++;
    we = 1'b0;
    tick();
    n_checks++;
    if (wr_ack !== 1'b0) $display("FAIL basic_ack_drop: got %b want 0", wr_ack);
    else n_pass++;
    raddr_a = 3'd5; raddr_b = 3'd2;
    #1;
    n_checks++;
    if (rdata_a !== 16'h1234 || rdata_b !== 16'hA5A5)
      $display("FAIL basic_read: got a=%h b=%h want 1234 a5a5", rdata_a, rdata_b);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr_a = 3'd0; raddr_b = 3'd0;
    #1;
    n_checks++;
    if (rdata_a !== 16'h0) $display("FAIL zero_bypass: got %h want 0000", rdata_a);
    else n_pass++;
    tick();
    n_checks++;
    if (wr_ack !== 1'b0) $display("FAIL zero_ack: got %b want 0", wr_ack);
    else n_pass++;
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(7 - i);
      #1;
      n_checks++;
      if (rdata_a !== exp_read(raddr_a) || rdata_b !== exp_read(raddr_b))
        $display("FAIL zero_unchanged_%0d: got a=%h b=%h want %h %h", i,
                 rdata_a, rdata_b, exp_read(raddr_a), exp_read(raddr_b));
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 3'd4; wdata = 16'h0011;
    tick();
    wdata = 16'h0022; raddr_a = 3'd4; raddr_b = 3'd4;
    #1;
    n_checks++;
    if (rdata_a !== 16'h0022 || rdata_b !== 16'h0022)
      $display("FAIL bypass_same_cycle: got a=%h b=%h want 0022", rdata_a, rdata_b);
    else n_pass++;
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata_a !== 16'h0022 || rdata_b !== 16'h0022)
      $display("FAIL bypass_stored: got a=%h b=%h want 0022", rdata_a, rdata_b);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    we = 1'b1; waddr = 3'd6; wdata = 16'h7777;
    tick();
    we = 1'b0; raddr_a = 3'd6;
    #1;
    n_checks++;
    if (rdata_a !== 16'h7777) $display("FAIL async_pre: got %h want 7777", rdata_a);
    else n_pass++;
    #1 rst = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if (rdata_a !== 16'h0 || wr_ack !== 1'b0)
      $display("FAIL async_immediate: got rdata_a=%h wr_ack=%b want 0000 0", rdata_a, wr_ack);
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    #1;
    n_checks++;
    if (rdata_a !== 16'h0) $display("FAIL async_after_release: got %h want 0000", rdata_a);
    else n_pass++;
  endtask

  task automatic test_collision();
    @(negedge clk);
    rst = 1'b0; we = 1'b1; waddr = 3'd1; wdata = 16'h0F0F; raddr_a = 3'd1;
    clear_model();
    tick();
    we = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (rdata_a !== 16'h0) $display("FAIL collision_R1: got %h want 0000", rdata_a);
    else n_pass++;
  endtask

  task automatic test_random();
    int rd_errs = 0;
    int ack_errs = 0;
    for (int n = 0; n < 300; n++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 3'($urandom_range(0, 7));
      wdata   = 16'($urandom);
      raddr_a = 3'($urandom_range(0, 7));
      raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) raddr_a = waddr;
      #1;
      n_checks++;
      if (rdata_a !== exp_read(raddr_a) || rdata_b !== exp_read(raddr_b)) begin
        if (rd_errs < 5)
          $display("FAIL random_read_%0d: got a=%h b=%h want %h %h", n,
                   rdata_a, rdata_b, exp_read(raddr_a), exp_read(raddr_b));
        rd_errs++;
      end else n_pass++;
      tick();
      n_checks++;
      if (wr_ack !== ack_exp) begin
        if (ack_errs < 5)
          $display("FAIL random_ack_%0d: got %b want %b", n, wr_ack, ack_exp);
        ack_errs++;
      end else n_pass++;
    end
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    ack_exp = 1'b0;
    clear_model();
    #3;
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_async_reset();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
